// File: rtl/spi_flash_reader.sv
// Single-bit SPI master fetching little-endian 32-bit words from serial flash.
// Wakes the flash with 0xAB after reset, then serves standard READ (0x03) requests.
//
// state     | meaning
// WAKE_CMD  | shifting the 0xAB release-from-power-down command
// WAKE_WAIT | csn high, waiting for the flash to wake up
// IDLE      | read_ready high, waiting for a request
// SHIFT     | 64-bit READ transfer: opcode, address, 32 data bits
// DESELECT  | csn held high before the next command
module spi_flash_reader #(
    parameter int DIVIDER     = 1,
    parameter int CS_HIGH     = 2,
    parameter int WAKE_CYCLES = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_valid,
    output logic        read_ready,
    input  logic [23:0] read_address,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    output logic        flash_clk,
    output logic        flash_csn,
    output logic        flash_io0_en,
    output logic        flash_io0_out,
    output logic        flash_io1_en,
    output logic        flash_io1_out,
    input  logic        flash_io1_in
);

    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        SHIFT,
        DESELECT
    } state_t;

    localparam logic [7:0]  HALF_LOAD = 8'(DIVIDER - 1);
    localparam logic [15:0] WAKE_LOAD = 16'(WAKE_CYCLES - 1);
    localparam logic [15:0] CS_LOAD   = 16'(CS_HIGH - 1);

    state_t      state;
    state_t      state_next;
    logic        run;
    logic [7:0]  half_cnt;
    logic        phase;
    logic [5:0]  bit_cnt;
    logic [15:0] wait_cnt;
    logic [63:0] tx_shift;
    logic [31:0] rx_shift;

    logic shifting;
    logic half_end;
    logic rise;
    logic bit_end;
    logic last_bit;
    logic accept;

    // run holds the bus idle for the cycle(s) reset is still asserted
    assign shifting = run && ((state == WAKE_CMD) || (state == SHIFT));
    assign half_end = shifting && (half_cnt == 8'd0);
    assign rise     = half_end && !phase;
    assign bit_end  = half_end && phase;
    assign last_bit = bit_end && (bit_cnt == 6'd0);
    assign accept   = read_valid && read_ready;

    assign read_ready    = (state == IDLE);
    assign flash_csn     = !shifting;
    assign flash_clk     = shifting && phase;
    assign flash_io0_en  = shifting;
    assign flash_io0_out = shifting && tx_shift[63];
    assign flash_io1_en  = 1'b0;
    assign flash_io1_out = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAKE_CMD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAKE_CMD:  if (last_bit) state_next = WAKE_WAIT;
            WAKE_WAIT: if (wait_cnt == 16'd0) state_next = IDLE;
            IDLE:      if (accept) state_next = SHIFT;
            SHIFT:     if (last_bit) state_next = DESELECT;
            DESELECT:  if (wait_cnt == 16'd0) state_next = IDLE;
            default:   state_next = WAKE_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run             <= 1'b0;
            half_cnt        <= HALF_LOAD;
            phase           <= 1'b0;
            bit_cnt         <= 6'd7;
            wait_cnt        <= 16'd0;
            tx_shift        <= {8'hAB, 56'd0};
            rx_shift        <= 32'd0;
            read_data       <= 32'd0;
            read_data_valid <= 1'b0;
        end else begin
            run             <= 1'b1;
            read_data_valid <= 1'b0;

            if (shifting) begin
                if (half_cnt == 8'd0) begin
                    half_cnt <= HALF_LOAD;
                    phase    <= !phase;
                end else begin
                    half_cnt <= half_cnt - 8'd1;
                end
            end

            // MISO is sampled on the edge that raises SCLK
            if (rise) begin
                rx_shift <= {rx_shift[30:0], flash_io1_in};
            end

            if (bit_end) begin
                tx_shift <= {tx_shift[62:0], 1'b0};
                bit_cnt  <= bit_cnt - 6'd1;
            end

            if ((state == WAKE_WAIT) || (state == DESELECT)) begin
                if (wait_cnt != 16'd0) begin
                    wait_cnt <= wait_cnt - 16'd1;
                end
            end

            if (last_bit && (state == WAKE_CMD)) begin
                wait_cnt <= WAKE_LOAD;
            end

            if (last_bit && (state == SHIFT)) begin
                wait_cnt        <= CS_LOAD;
                read_data_valid <= 1'b1;
                read_data       <= {rx_shift[7:0], rx_shift[15:8],
                                    rx_shift[23:16], rx_shift[31:24]};
            end

            if (accept) begin
                tx_shift <= {8'h03, read_address, 32'd0};
                bit_cnt  <= 6'd63;
                half_cnt <= HALF_LOAD;
                phase    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader: two instances (DIVIDER 1 and 3), each with
// a small flash model; stimulus pushes expectations, monitors pop and compare.
module tb_spi_flash_reader;

    typedef struct {
        int          bits;
        logic [63:0] mosi;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    longint cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int DIV = (g == 0) ? 1 : 3;

        logic        reset = 1'b1;
        logic        read_valid = 1'b0;
        logic [23:0] read_address = 24'd0;
        logic        read_ready;
        logic [31:0] read_data;
        logic        read_data_valid;
        logic        flash_clk;
        logic        flash_csn;
        logic        flash_io0_en;
        logic        flash_io0_out;
        logic        flash_io1_en;
        logic        flash_io1_out;
        logic        flash_io1_in;
        logic        done_flag = 1'b0;

        spi_flash_reader #(.DIVIDER(DIV), .CS_HIGH(2), .WAKE_CYCLES(48)) dut (
            .clk            (clk),
            .reset          (reset),
            .read_valid     (read_valid),
            .read_ready     (read_ready),
            .read_address   (read_address),
            .read_data      (read_data),
            .read_data_valid(read_data_valid),
            .flash_clk      (flash_clk),
            .flash_csn      (flash_csn),
            .flash_io0_en   (flash_io0_en),
            .flash_io0_out  (flash_io0_out),
            .flash_io1_en   (flash_io1_en),
            .flash_io1_out  (flash_io1_out),
            .flash_io1_in   (flash_io1_in)
        );

        cmd_t        exp_cmd[$];
        logic [31:0] resp_q[$];
        logic [31:0] exp_data[$];
        longint      exp_cyc[$];

        // flash model: captures MOSI on SCLK rise, shifts MISO on SCLK fall
        logic [63:0] miso_sr = 64'd0;
        logic [63:0] mosi_sr = 64'd0;
        int          rises = 0;
        bit          sel = 1'b0;
        longint      t_low = 0, t_high = 0, t_csn_rise = 0;
        longint      min_gap = 0;
        assign flash_io1_in = miso_sr[63];

        always @(negedge flash_csn) begin
            check("csn_gap", (($time - t_csn_rise) / 10) >= min_gap, 1'b1);
            sel     = 1'b1;
            t_low   = $time;
            mosi_sr = 64'd0;
            rises   = 0;
            miso_sr = (resp_q.size() != 0) ? {32'd0, resp_q.pop_front()} : 64'd0;
        end

        always @(posedge flash_clk) begin
            if (flash_csn == 1'b0) begin
                check("sclk_low_len", ($time - t_low) / 10, DIV);
                t_high  = $time;
                mosi_sr = {mosi_sr[62:0], flash_io0_out};
                rises++;
            end
        end

        always @(negedge flash_clk) begin
            if (flash_csn == 1'b0) begin
                check("sclk_high_len", ($time - t_high) / 10, DIV);
                t_low   = $time;
                miso_sr = {miso_sr[62:0], 1'b0};
            end
        end

        always @(posedge flash_csn) begin
            t_csn_rise = $time;
            if (sel) begin
                sel = 1'b0;
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", exp_cmd.size(), 1);
                end else begin
                    cmd_t e;
                    e = exp_cmd.pop_front();
                    if (e.bits != 0) begin
                        check("cmd_bits", rises, e.bits);
                        check("cmd_mosi", mosi_sr, e.mosi);
                    end
                    min_gap = (e.bits == 8) ? 48 : 2;
                end
            end
        end

        // response monitor
        longint ready_due = -1;
        always @(negedge clk) begin
            if (reset) begin
                exp_cyc.delete();
                ready_due = -1;
            end else begin
                if (read_valid && read_ready)
                    exp_cyc.push_back(cycle + 1 + 128 * DIV);
                if (read_data_valid) begin
                    if (exp_data.size() == 0)
                        check("valid_unexpected", read_data_valid, 1'b0);
                    else
                        check("read_data", read_data, exp_data.pop_front());
                    if (exp_cyc.size() != 0)
                        check("valid_latency", cycle, exp_cyc.pop_front());
                    ready_due = cycle + 2;
                end
                if (cycle == ready_due)
                    check("ready_return", read_ready, 1'b1);
                if (flash_csn)
                    check("sclk_idle", flash_clk, 1'b0);
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic push_txn(input int bits, input logic [63:0] mosi, input logic [31:0] resp);
            cmd_t e;
            e.bits = bits;
            e.mosi = mosi;
            exp_cmd.push_back(e);
            resp_q.push_back(resp);
        endtask

        task automatic wait_ready(input int limit);
            int n = 0;
            while (!read_ready && n < limit) begin
                tick();
                n++;
            end
            if (!read_ready) check("ready_timeout", read_ready, 1'b1);
        endtask

        task automatic wait_valid(input int limit);
            int n = 0;
            while (!read_data_valid && n < limit) begin
                tick();
                n++;
            end
            if (!read_data_valid) check("valid_timeout", read_data_valid, 1'b1);
        endtask

        task automatic wait_csn(input logic lvl, input int limit);
            int n = 0;
            while (flash_csn !== lvl && n < limit) begin
                tick();
                n++;
            end
            if (flash_csn !== lvl) check("csn_timeout", flash_csn, lvl);
        endtask

        task automatic check_reset_values(input string tag);
            check({tag, "_csn"}, flash_csn, 1'b1);
            check({tag, "_sclk"}, flash_clk, 1'b0);
            check({tag, "_io0_en"}, flash_io0_en, 1'b0);
            check({tag, "_io0_out"}, flash_io0_out, 1'b0);
            check({tag, "_ready"}, read_ready, 1'b0);
            check({tag, "_data"}, read_data, 32'd0);
            check({tag, "_valid"}, read_data_valid, 1'b0);
        endtask

        if (g == 0) begin : s_div1
            initial begin
                longint c0;
                longint v1;
                int n;
                repeat (3) tick();
                check_reset_values("rst");
                push_txn(8, 64'hAB, 32'd0);
                reset = 1'b0;

                // request raised during wake-up must wait for read_ready
                read_valid   = 1'b1;
                read_address = 24'h012345;
                push_txn(64, {8'h03, 24'h012345, 32'd0}, 32'hEFBEADDE);
                exp_data.push_back(32'hDEADBEEF);
                wait_csn(1'b0, 20);
                wait_csn(1'b1, 40);
                c0 = cycle;
                check("wake_ready_low", read_ready, 1'b0);
                wait_ready(200);
                check("wake_wait_len", cycle - c0, 48);
                tick();
                read_valid = 1'b0;
                wait_valid(300);
                repeat (5) tick();

                // back-to-back with read_valid held
                push_txn(64, {8'h03, 24'h000000, 32'd0}, 32'h11223344);
                exp_data.push_back(32'h44332211);
                push_txn(64, {8'h03, 24'hABCDEF, 32'd0}, 32'hA55A0FF0);
                exp_data.push_back(32'hF00F5AA5);
                read_address = 24'h000000;
                read_valid   = 1'b1;
                wait_ready(10);
                tick();
                read_address = 24'hABCDEF;
                wait_valid(300);
                v1 = cycle;
                wait_ready(10);
                check("b2b_gap", cycle - v1, 2);
                tick();
                read_valid = 1'b0;
                tick();
                wait_valid(300);
                repeat (5) tick();

                // reset in the middle of a read
                push_txn(0, 64'd0, 32'h55AA55AA);
                read_address = 24'h00F00D;
                read_valid   = 1'b1;
                wait_ready(10);
                tick();
                read_valid = 1'b0;
                n = 0;
                while (rises < 40 && n < 200) begin
                    tick();
                    n++;
                end
                if (rises < 40) check("rise_timeout", rises, 40);
                reset = 1'b1;
                tick();
                check_reset_values("abort");
                push_txn(8, 64'hAB, 32'd0);
                tick();
                reset = 1'b0;

                read_address = 24'h7FFFFF;
                read_valid   = 1'b1;
                push_txn(64, {8'h03, 24'h7FFFFF, 32'd0}, 32'h01020304);
                exp_data.push_back(32'h04030201);
                wait_ready(300);
                tick();
                read_valid = 1'b0;
                wait_valid(300);
                repeat (5) tick();
                check("data_hold", read_data, 32'h04030201);
                check("cmd_left", exp_cmd.size(), 0);
                check("data_left", exp_data.size(), 0);
                done_flag = 1'b1;
            end
        end else begin : s_div3
            initial begin
                repeat (3) tick();
                check_reset_values("rst3");
                push_txn(8, 64'hAB, 32'd0);
                reset = 1'b0;
                read_valid   = 1'b1;
                read_address = 24'hFFFFFC;
                push_txn(64, {8'h03, 24'hFFFFFC, 32'd0}, 32'h0DF0FECA);
                exp_data.push_back(32'hCAFEF00D);
                wait_ready(500);
                tick();
                read_valid = 1'b0;
                wait_valid(1000);
                repeat (8) tick();
                check("cmd_left3", exp_cmd.size(), 0);
                check("data_left3", exp_data.size(), 0);
                done_flag = 1'b1;
            end
        end
    end

    initial begin
        int n = 0;
        while (!(u[0].done_flag && u[1].done_flag) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!(u[0].done_flag && u[1].done_flag))
            check("finish_timeout", u[0].done_flag && u[1].done_flag, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
